// File: rtl/mult_seq_ctrl_if.sv
// Handshake and shared-adder bus for the shift-add multiplier sequencer.
// slave = sequencer side, master = requester plus external adder side.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   add_inA;
  logic [WIDTH-1:0]   add_inB;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  modport slave (
    input  start, op_a, op_b, add_sum, add_cout,
    output ready, busy, done, result, add_inA, add_inB, add_cin
  );

  modport master (
    output start, op_a, op_b, add_sum, add_cout,
    input  ready, busy, done, result, add_inA, add_inB, add_cin
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Unsigned shift-add multiplier sequencer driving a shared external adder.
// Optional macro MULT_ZERO_SKIP_EN: zero operands finish in one cycle.
module mult_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_skip;

  assign w_accept = (r_state != S_RUN) && bus.start;

`ifdef MULT_ZERO_SKIP_EN
  assign w_skip = (bus.op_a == '0) || (bus.op_b == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_next = w_skip ? S_DONE : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_count == LAST_CNT) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The adder carry-out becomes the new MSB so the running partial product never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_mcand <= bus.op_a;
      r_hi    <= '0;
      r_lo    <= w_skip ? '0 : bus.op_b;
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_hi    <= {bus.add_cout, bus.add_sum[WIDTH-1:1]};
      r_lo    <= {bus.add_sum[0], r_lo[WIDTH-1:1]};
      r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    bus.ready   = (r_state != S_RUN);
    bus.busy    = (r_state == S_RUN);
    bus.done    = (r_state == S_DONE);
    bus.result  = {r_hi, r_lo};
    bus.add_cin = 1'b0;
    bus.add_inA = '0;
    bus.add_inB = '0;
    if (r_state == S_RUN) begin
      bus.add_inA = r_hi;
      bus.add_inB = r_lo[0] ? r_mcand : '0;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: arithmetic reference model plus directed
// and random multiplications, with the shared adder modelled behaviourally.
module tb_mult_seq_ctrl;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   carryCount;

  mult_seq_ctrl_if #(.WIDTH(W)) bus ();

  mult_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_inA} + {1'b0, bus.add_inB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Contents of {hi,lo} after s shift-add steps: the partial product of the
  // low s multiplier bits sits on top, the unconsumed multiplier bits below.
  function automatic logic [31:0] partialState(input logic [15:0] a, input logic [15:0] b, input int s);
    logic [63:0] mask;
    logic [63:0] p;
    logic [63:0] rest;
    mask = (64'd1 << s) - 64'd1;
    p    = ({48'd0, a} * ({48'd0, b} & mask)) << (W - s);
    rest = {48'd0, b} >> s;
    return p[31:0] | rest[31:0];
  endfunction

  function automatic int latencyFor(input logic [15:0] a, input logic [15:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (a == 16'd0 || b == 16'd0) return 1;
`endif
    return W + 1;
  endfunction

  // Reference model: cycle index since accept, operands, and the held product.
  bit          mActive;
  int          mK;
  int          mLat;
  logic [15:0] mA;
  logic [15:0] mB;
  logic [31:0] mHeld;

  initial begin
    logic        expReady, expBusy, expDone;
    logic [31:0] expRes;
    logic [15:0] expInA, expInB;
    mActive = 1'b0; mK = 0; mLat = 0; mA = '0; mB = '0; mHeld = '0;
    carryCount = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mActive = 1'b0;
        mHeld   = '0;
      end else begin
        expInA = '0; expInB = '0;
        if (mActive && mK < mLat) begin
          expReady = 1'b0; expBusy = 1'b1; expDone = 1'b0;
          expRes   = partialState(mA, mB, mK - 1);
          expInA   = expRes[31:16];
          expInB   = (((mB >> (mK - 1)) & 16'd1) != 16'd0) ? mA : 16'd0;
        end else if (mActive && mK == mLat) begin
          expReady = 1'b1; expBusy = 1'b0; expDone = 1'b1;
          expRes   = {16'd0, mA} * {16'd0, mB};
        end else begin
          expReady = 1'b1; expBusy = 1'b0; expDone = 1'b0;
          expRes   = mHeld;
        end
        checkOutput("ready",   64'(bus.ready),   64'(expReady));
        checkOutput("busy",    64'(bus.busy),    64'(expBusy));
        checkOutput("done",    64'(bus.done),    64'(expDone));
        checkOutput("result",  64'(bus.result),  64'(expRes));
        checkOutput("add_inA", 64'(bus.add_inA), 64'(expInA));
        checkOutput("add_inB", 64'(bus.add_inB), 64'(expInB));
        checkOutput("add_cin", 64'(bus.add_cin), 64'd0);
        if (expBusy && bus.add_cout) carryCount++;

        if (bus.start && expReady) begin
          mA = bus.op_a; mB = bus.op_b;
          mActive = 1'b1; mK = 1;
          mLat = latencyFor(bus.op_a, bus.op_b);
        end else if (mActive) begin
          if (mK == mLat) begin
            mActive = 1'b0;
            mHeld   = {16'd0, mA} * {16'd0, mB};
          end else begin
            mK++;
          end
        end
      end
    end
  end

  // Raise start with operands, hold it until accepted, drop it after the accept edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    int n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.ready) break;
      n++;
      if (n > 100) begin
        checkOutput("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Returns the cycle number (accept = 0) in which done is first seen.
  task automatic waitDone(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
      if (cyc > 60) begin
        checkOutput("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  initial begin
    int          cyc;
    int          c0;
    int          dones;
    logic [15:0] ra, rb;
    compared = 0; mismatched = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready",  64'(bus.ready),  64'd1);
    checkOutput("rst_busy",   64'(bus.busy),   64'd0);
    checkOutput("rst_result", 64'(bus.result), 64'd0);

    applyStimulus(16'd3, 16'd5);
    @(negedge clk);
    checkOutput("basic_busy_c1", 64'(bus.busy), 64'd1);
    waitDone(cyc);
    cyc = cyc + 1;
    checkOutput("basic_latency", 64'(cyc), 64'd17);
    checkOutput("basic_result",  64'(bus.result), 64'd15);

    c0 = carryCount;
    applyStimulus(16'hFFFF, 16'hFFFF);
    waitDone(cyc);
    checkOutput("carry_latency", 64'(cyc), 64'd17);
    checkOutput("carry_result",  64'(bus.result), 64'hFFFE0001);
    checkOutput("carry_seen",    64'(carryCount > c0), 64'd1);

    applyStimulus(16'd100, 16'd200);
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b1; bus.op_a = 16'd11; bus.op_b = 16'd13;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.start = 1'b1; bus.op_a = 16'd7; bus.op_b = 16'd9;
    @(negedge clk);
    checkOutput("ignore_done",   64'(bus.done),   64'd1);
    checkOutput("ignore_result", 64'(bus.result), 64'd20000);
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_busy", 64'(bus.busy), 64'd1);
    waitDone(cyc);
    cyc = cyc + 1;
    checkOutput("b2b_latency", 64'(cyc), 64'd17);
    checkOutput("b2b_result",  64'(bus.result), 64'd63);

    applyStimulus(16'd0, 16'h1234);
    waitDone(cyc);
`ifdef MULT_ZERO_SKIP_EN
    checkOutput("zero_latency", 64'(cyc), 64'd1);
`else
    checkOutput("zero_latency", 64'(cyc), 64'd17);
`endif
    checkOutput("zero_result", 64'(bus.result), 64'd0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("hold_result", 64'(bus.result), 64'd0);

    applyStimulus(16'h1234, 16'h5678);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready",  64'(bus.ready),  64'd1);
    checkOutput("midrst_busy",   64'(bus.busy),   64'd0);
    checkOutput("midrst_done",   64'(bus.done),   64'd0);
    checkOutput("midrst_result", 64'(bus.result), 64'd0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checkOutput("midrst_no_done", 64'(dones), 64'd0);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'd0;
        1: rb = 16'd0;
        2: begin ra = 16'hFFFF; rb = 16'($urandom_range(1, 65535)); end
        default: ;
      endcase
      applyStimulus(ra, rb);
      waitDone(cyc);
      checkOutput("rand_latency", 64'(cyc), 64'(latencyFor(ra, rb) - 1 + 1));
      checkOutput("rand_result", 64'(bus.result), {32'd0, ra} * {32'd0, rb});
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
